sgpu_fb_axi_rd_slave: RTL and testbench
=======================================

# sgpu_fb_axi_rd_slave

AXI4 read-channel responder serving the SGPU framebuffer fetch engine from a local 64-bit on-chip frame memory. It is the far end of the SGPU AR/R master: it accepts one INCR or FIXED read burst at a time and streams beats back with full `rready` backpressure support. It is used as the on-chip framebuffer in FPGA builds and as the memory model in simulation. A side write port lets the CPU or testbench fill pixel data.

## Interface
- `DEPTH`, 4096: 64-bit words of frame memory; power of two.
- `BASE_ADDR`, 32'hc000_0000: byte address mapped to word 0.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `s_axi_arvalid`  in  1  read address valid.
- `s_axi_arready`  out  1  read address ready.
- `s_axi_araddr`  in  32  byte address; bits [2:0] ignored.
- `s_axi_arburst`  in  2  0 FIXED, 1 INCR, 2 WRAP.
- `s_axi_arlen`  in  8  beats minus one.
- `s_axi_arsize`  in  3  must be 3 (8 bytes).
- `s_axi_arcache`/`arprot`/`arlock`  in  4/3/1  accepted and ignored.
- `s_axi_rvalid`  out  1  read data valid.
- `s_axi_rready`  in  1  read data ready.
- `s_axi_rdata`  out  64  read data.
- `s_axi_rresp`  out  2  0 OKAY, 2 SLVERR.
- `s_axi_rlast`  out  1  last beat of burst.
- `fill_en`  in  1  write strobe for fill port.
- `fill_addr`  in  log2(DEPTH)  word index.
- `fill_data`  in  64  write data.
- `fill_mask`  in  8  byte enables.

## Operation
- FSM states: IDLE, ISSUE, STREAM.
- IDLE: `arready`=1. On `arvalid&arready`, latch word address ((araddr-BASE_ADDR)>>3), remaining count = arlen, burst type, error flag; go ISSUE.
- ISSUE: first RAM read issued; go STREAM.
- STREAM: RAM reads issued whenever the 2-entry output buffer has a free slot counting the in-flight read; address +1 per read for INCR, held for FIXED; word address wraps modulo DEPTH.
- Beat counter decrements on each R handshake; `rlast`=1 on beat arlen only.
- R handshake carrying `rlast` returns FSM to IDLE.
- Error flag (see Configuration) forces every beat of the burst to `rresp`=2, `rdata`=0; burst length still honoured.
- RAM is synchronous-read, read-first: a fill write and a read to the same word in one cycle returns the old word. Fill writes honour `fill_mask` per byte and are accepted in every state.
- `rdata`/`rresp`/`rlast` held stable while `rvalid`=1 and `rready`=0.

## Timing
- Reset: `arready`=0 during reset, 1 first cycle after; `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0; FSM IDLE; buffer empty; memory contents not cleared.
- AR handshake in cycle 0 -> `rvalid`=1 in cycle 2 with beat 0.
- With `rready` held 1: one beat per cycle, no bubbles.
- `arready` deasserts the cycle after AR handshake; reasserts the cycle after the `rlast` handshake (one burst outstanding max).
- `rready` low any number of cycles: no beat lost or duplicated; buffer never exceeds 2.
- Reset mid-burst: burst discarded, outputs to reset values next cycle.

## Configuration
- `SGPU_FB_RD_ERRCHK_EN` defined: error flag set when address outside [BASE_ADDR, BASE_ADDR+8*DEPTH), or `arsize`≠3, or `arburst`=2/3; beats return SLVERR.
- Undefined: no checks; all beats OKAY; address offset taken modulo DEPTH; WRAP treated as INCR.

## Structure
- Shared package `sgpu_axi_pkg`: RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP codes, FSM state encoding.
- One sub-module: `sgpu_rd_skid`, 2-entry output buffer holding {rdata, rresp, rlast} with valid/ready both sides.
- RAM inferred inline.

## Test plan
- Fill words 0..15 with i*0x0101; INCR arlen=15 at BASE_ADDR, rready=1 -> 16 beats cycles 2..17, data i*0x0101, rlast only on 16th, rresp=0.
- Same burst, rready toggled 1-0-1-0 -> identical data sequence, each beat held while stalled.
- FIXED arlen=3 at BASE_ADDR+0x20 -> four beats all = word 4.
- Fill word 7 in the cycle its read issues -> old value returned; reread returns new value.
- With `SGPU_FB_RD_ERRCHK_EN`: araddr=BASE_ADDR+8*DEPTH, arlen=1 -> 2 beats rresp=2, rdata=0; without macro -> word 0, rresp=0.
- Assert rst at beat 3 of 8-beat burst -> rvalid=0 next cycle, arready=1 after release, new burst correct.

Source files
------------

// File: rtl/sgpu_axi_pkg.sv
// ---------------------------------------------------------------------------
// sgpu_axi_pkg
//   Shared AXI constants and types for the SGPU framebuffer read responder.
//   Holds the RRESP and ARBURST encodings, the read-side FSM state type and
//   the beat record {rdata, rresp, rlast} carried through the output buffer.
// ---------------------------------------------------------------------------
package sgpu_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } rd_beat_t;

endpackage

// File: rtl/sgpu_rd_skid.sv
// ---------------------------------------------------------------------------
// sgpu_rd_skid
//   Two-entry output buffer for R beats. When empty, an arriving beat is
//   presented straight to the output so the first beat costs no extra cycle;
//   otherwise beats leave in arrival order from the stored slots. The output
//   side only depends on registered state, never on out_ready.
//
//   clk, rst      : clock, synchronous active-high reset (empties the buffer)
//   in_valid      : a beat is offered this cycle (RAM read data is valid)
//   in_ready      : a slot is free
//   in_beat       : beat offered {rdata, rresp, rlast}
//   out_valid     : a beat is presented on the R channel
//   out_ready     : R channel consumer accepts the beat
//   out_beat      : presented beat, all zero when nothing is presented
//   count         : number of stored beats (0..2)
// ---------------------------------------------------------------------------
module sgpu_rd_skid
    import sgpu_axi_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  rd_beat_t in_beat,
    output logic     out_valid,
    input  logic     out_ready,
    output rd_beat_t out_beat,
    output logic [1:0] count
);

    rd_beat_t   slot [2];
    logic       head;
    logic       tail;
    logic [1:0] cnt;
    logic       bypass;
    logic       push;
    logic       pop_slot;

    // Presentation and push/pop decisions. A beat arriving while the buffer
    // is empty and the consumer is ready goes straight through; any other
    // arriving beat is stored behind the ones already waiting.
    always_comb begin
        tail      = head ^ cnt[0];
        in_ready  = (cnt != 2'd2);
        out_valid = (cnt != 2'd0) || in_valid;
        out_beat  = '0;
        if (cnt != 2'd0) begin
            out_beat = slot[head];
        end else if (in_valid) begin
            out_beat = in_beat;
        end
        bypass   = (cnt == 2'd0) && in_valid && out_ready;
        push     = in_valid && !bypass && (cnt != 2'd2);
        pop_slot = (cnt != 2'd0) && out_ready;
        count    = cnt;
    end

    // Occupancy and read pointer; a reset simply forgets whatever is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= 1'b0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop_slot};
            if (pop_slot) begin
                head <= ~head;
            end
        end
    end

    // Slot storage needs no reset since occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[tail] <= in_beat;
        end
    end

endmodule

// File: rtl/sgpu_fb_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// sgpu_fb_axi_rd_slave
//   AXI4 read-channel responder backed by a local 64-bit frame memory. One
//   INCR or FIXED burst is accepted at a time and streamed back with full
//   rready backpressure. A side fill port writes pixel data with byte masks.
//
//   Optional build macro SGPU_FB_RD_ERRCHK_EN: when defined, a burst whose
//   start address lies outside the mapped window, whose arsize is not 8
//   bytes, or whose type is WRAP/reserved returns SLVERR with zero data on
//   every beat. When undefined, the address offset wraps modulo DEPTH and
//   WRAP bursts behave like INCR.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     s_axi_ar*                    read address channel (cache/prot/lock ignored)
//     s_axi_r*                     read data channel
//     fill_en/addr/data/mask       word-indexed fill write with byte enables
// ---------------------------------------------------------------------------
module sgpu_fb_axi_rd_slave
    import sgpu_axi_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'hc000_0000
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [31:0]              s_axi_araddr,
    input  logic [1:0]               s_axi_arburst,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [3:0]               s_axi_arcache,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arlock,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [63:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    input  logic                     fill_en,
    input  logic [$clog2(DEPTH)-1:0] fill_addr,
    input  logic [63:0]              fill_data,
    input  logic [7:0]               fill_mask
);

    localparam int AW = $clog2(DEPTH);

    rd_state_t   state;
    logic        arready_q;
    logic [AW-1:0] rd_addr;
    logic [8:0]  reads_left;
    logic        burst_fixed;
    logic        burst_err;

    logic [63:0] mem [DEPTH];
    logic [63:0] rd_q;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_err;

    logic [31:0] ar_offset;
    logic        ar_err;
    logic        ar_fire;
    logic        rd_issue;
    logic        space_ok;
    logic        pop;

    rd_beat_t    in_beat;
    rd_beat_t    out_beat;
    logic        out_valid;
    logic        skid_in_ready;
    logic [1:0]  skid_count;
    logic        unused_inputs;

    assign ar_offset = s_axi_araddr - BASE_ADDR;
    assign ar_fire   = s_axi_arvalid && arready_q;

`ifdef SGPU_FB_RD_ERRCHK_EN
    assign ar_err = (ar_offset[31:3] >= 29'(DEPTH)) ||
                    (s_axi_arsize != 3'd3) ||
                    s_axi_arburst[1];
`else
    assign ar_err = 1'b0;
`endif

    assign unused_inputs = ^{s_axi_arcache, s_axi_arprot, s_axi_arlock,
                             ar_offset, s_axi_arsize, s_axi_arburst,
                             skid_in_ready};

    // Read issue decision. The buffer must be able to absorb every read in
    // flight even if the consumer stalls from now on, so the stored beats
    // plus the beat coming out of the RAM, less the one leaving this cycle,
    // must leave room for one more.
    always_comb begin
        pop      = out_valid && s_axi_rready;
        space_ok = ({1'b0, skid_count} + {2'b00, rd_valid}) <= (3'd1 + {2'b00, pop});
        rd_issue = (state == ISSUE) ||
                   ((state == STREAM) && (reads_left != 9'd0) && space_ok);
    end

    // Burst control: accept one AR in IDLE, issue the first read in ISSUE,
    // then keep reading in STREAM until the last beat is handed over.
    // arready is registered so it drops the cycle after the AR handshake
    // and comes back the cycle after the rlast handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            arready_q   <= 1'b0;
            rd_addr     <= '0;
            reads_left  <= 9'd0;
            burst_fixed <= 1'b0;
            burst_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        arready_q   <= 1'b0;
                        rd_addr     <= ar_offset[AW+2:3];
                        reads_left  <= {1'b0, s_axi_arlen} + 9'd1;
                        burst_fixed <= (s_axi_arburst == BURST_FIXED);
                        burst_err   <= ar_err;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop && out_beat.rlast) begin
                        state     <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (rd_issue) begin
                reads_left <= reads_left - 9'd1;
                if (!burst_fixed) begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
        end
    end

    // Frame memory: byte-masked fill writes in any state, synchronous
    // read-first read port. Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            for (int b = 0; b < 8; b++) begin
                if (fill_mask[b]) begin
                    mem[fill_addr][8*b +: 8] <= fill_data[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Side-band for the read in flight: whether RAM data is valid this cycle,
    // whether it is the last beat of the burst, and whether the burst errored.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
            rd_last  <= (reads_left == 9'd1);
            rd_err   <= burst_err;
        end
    end

    // Errored bursts return zero data with SLVERR on every beat.
    always_comb begin
        in_beat.rdata = rd_err ? 64'd0 : rd_q;
        in_beat.rresp = rd_err ? RESP_SLVERR : RESP_OKAY;
        in_beat.rlast = rd_last;
    end

    sgpu_rd_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_ready  (skid_in_ready),
        .in_beat   (in_beat),
        .out_valid (out_valid),
        .out_ready (s_axi_rready),
        .out_beat  (out_beat),
        .count     (skid_count)
    );

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = out_valid;
    assign s_axi_rdata   = out_beat.rdata;
    assign s_axi_rresp   = out_beat.rresp;
    assign s_axi_rlast   = out_beat.rlast;

endmodule

// File: tb/tb_sgpu_fb_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// tb_sgpu_fb_axi_rd_slave
//   Self-checking bench for the framebuffer AXI read responder. A word-level
//   memory model plus the burst address/error rules predict every beat; the
//   R channel is driven with steady, alternating and random rready patterns.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sgpu_fb_axi_rd_slave;
    import sgpu_axi_pkg::*;

    localparam int          DEPTH     = 4096;
    localparam logic [31:0] BASE_ADDR = 32'hc000_0000;
    localparam int          AW        = $clog2(DEPTH);

`ifdef SGPU_FB_RD_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_araddr;
    logic [1:0]    s_axi_arburst;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [3:0]    s_axi_arcache;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arlock;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [63:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          fill_en;
    logic [AW-1:0] fill_addr;
    logic [63:0]   fill_data;
    logic [7:0]    fill_mask;

    int assertions = 0;
    int failures   = 0;

    logic [63:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    sgpu_fb_axi_rd_slave #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arcache (s_axi_arcache),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arlock  (s_axi_arlock),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .fill_en       (fill_en),
        .fill_addr     (fill_addr),
        .fill_data     (fill_data),
        .fill_mask     (fill_mask)
    );

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference rule: does this AR request produce an error burst?
    function automatic bit burstErr(input logic [31:0] addr, input logic [1:0] burst,
                                    input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ERRCHK && ((off >= 32'(8 * DEPTH)) || (size != 3'd3) || (burst >= 2'd2));
    endfunction

    // Reference rule: which memory word beat k of a burst reads.
    function automatic int beatWord(input logic [31:0] addr, input logic [1:0] burst,
                                    input int k);
        longint w;
        w = longint'((addr - BASE_ADDR) >> 3);
        if (burst != BURST_FIXED) begin
            w = w + longint'(k);
        end
        return int'(w % longint'(DEPTH));
    endfunction

    // Fill one word through the side port (called on a falling edge).
    task automatic fillWord(input int idx, input logic [63:0] data, input logic [7:0] mask);
        fill_en   = 1'b1;
        fill_addr = AW'(idx);
        fill_data = data;
        fill_mask = mask;
        @(negedge clk);
        fill_en = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
                model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    // Present one AR request and complete the handshake; returns on the
    // falling edge of the cycle after the handshake.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] burst,
                                 input logic [7:0] len, input logic [2:0] size);
        int waited;
        waited = 0;
        while (!s_axi_arready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("arready_wait", 64'(s_axi_arready), 64'd1);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arburst = burst;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arcache = 4'($urandom);
        s_axi_arprot  = 3'($urandom);
        s_axi_arlock  = 1'($urandom);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    // Run one complete burst and compare every presented beat with the
    // model. mode 0: rready always 1 (also checks per-cycle rvalid timing),
    // mode 1: rready 1-0-1-0 from the first beat cycle, mode 2: random.
    // A fill write can be injected in cycle fill_cyc (counted from the AR
    // handshake cycle as 0); the expected data is captured before it.
    task automatic runBurst(input string name, input logic [31:0] addr,
                            input logic [1:0] burst, input logic [7:0] len,
                            input logic [2:0] size, input int mode,
                            input int fill_cyc, input int fill_idx,
                            input logic [63:0] fill_val);
        logic [63:0] exp_data [$];
        logic [1:0]  exp_resp;
        bit          err;
        int          k;
        int          cyc;
        int          first_seen;
        err      = burstErr(addr, burst, size);
        exp_resp = err ? RESP_SLVERR : RESP_OKAY;
        for (int i = 0; i <= int'(len); i++) begin
            exp_data.push_back(err ? 64'd0 : model_mem[beatWord(addr, burst, i)]);
        end
        k          = 0;
        first_seen = -1;
        applyStimulus(addr, burst, len, size);
        checkOutput({name, "_arready_low"}, 64'(s_axi_arready), 64'd0);
        cyc = 1;
        while (k <= int'(len) && cyc < 600) begin
            if (cyc == fill_cyc) begin
                fill_en   = 1'b1;
                fill_addr = AW'(fill_idx);
                fill_data = fill_val;
                fill_mask = 8'hff;
            end else if (fill_cyc >= 0 && cyc == fill_cyc + 1) begin
                fill_en             = 1'b0;
                model_mem[fill_idx] = fill_val;
            end
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = ((cyc % 2) == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) begin
                checkOutput({name, "_rvalid_timing"}, 64'(s_axi_rvalid), 64'(cyc >= 2));
            end
            if (s_axi_rvalid) begin
                if (first_seen < 0) begin
                    first_seen = cyc;
                end
                checkOutput({name, "_rdata"}, s_axi_rdata, exp_data[k]);
                checkOutput({name, "_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
                checkOutput({name, "_rlast"}, 64'(s_axi_rlast), 64'(k == int'(len)));
                if (s_axi_rready) begin
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (fill_en) begin
            fill_en             = 1'b0;
            model_mem[fill_idx] = fill_val;
        end
        checkOutput({name, "_beats"}, 64'(k), 64'(int'(len) + 1));
        checkOutput({name, "_first_beat_cycle"}, 64'(first_seen), 64'd2);
        checkOutput({name, "_arready_back"}, 64'(s_axi_arready), 64'd1);
        checkOutput({name, "_rvalid_after"}, 64'(s_axi_rvalid), 64'd0);
    endtask

    // Directed steps followed by randomized bursts against the model.
    initial begin
        rst           = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arburst = BURST_INCR;
        s_axi_arlen   = '0;
        s_axi_arsize  = 3'd3;
        s_axi_arcache = '0;
        s_axi_arprot  = '0;
        s_axi_arlock  = 1'b0;
        s_axi_rready  = 1'b0;
        fill_en       = 1'b0;
        fill_addr     = '0;
        fill_data     = '0;
        fill_mask     = '0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_arready", 64'(s_axi_arready), 64'd0);
        checkOutput("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        checkOutput("rst_rlast", 64'(s_axi_rlast), 64'd0);
        checkOutput("rst_rresp", 64'(s_axi_rresp), 64'd0);
        checkOutput("rst_rdata", s_axi_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_arready", 64'(s_axi_arready), 64'd1);

        $display("[TB] fill words 0..15 and stream them back");
        for (int i = 0; i < 16; i++) begin
            fillWord(i, 64'(i) * 64'h0101, 8'hff);
        end
        runBurst("incr16", BASE_ADDR, BURST_INCR, 8'd15, 3'd3, 0, -1, 0, 64'd0);
        runBurst("incr16_toggle", BASE_ADDR, BURST_INCR, 8'd15, 3'd3, 1, -1, 0, 64'd0);
        runBurst("fixed4", BASE_ADDR + 32'h20, BURST_FIXED, 8'd3, 3'd3, 0, -1, 0, 64'd0);

        $display("[TB] fill collides with read of word 7");
        runBurst("rdfirst", BASE_ADDR, BURST_INCR, 8'd15, 3'd3, 0, 8, 7,
                 64'hdead_beef_0000_7777);
        runBurst("reread7", BASE_ADDR + 32'h38, BURST_FIXED, 8'd0, 3'd3, 0, -1, 0, 64'd0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(BASE_ADDR, BURST_INCR, 8'd7, 3'd3);
        s_axi_rready = 1'b1;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
        end
        checkOutput("midrst_beat3", s_axi_rdata, model_mem[3]);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
        checkOutput("midrst_rlast", 64'(s_axi_rlast), 64'd0);
        checkOutput("midrst_rdata", s_axi_rdata, 64'd0);
        checkOutput("midrst_arready", 64'(s_axi_arready), 64'd0);
        rst          = 1'b0;
        s_axi_rready = 1'b0;
        @(negedge clk);
        checkOutput("midrst_arready_back", 64'(s_axi_arready), 64'd1);
        checkOutput("midrst_rvalid_idle", 64'(s_axi_rvalid), 64'd0);
        runBurst("post_midrst", BASE_ADDR + 32'h40, BURST_INCR, 8'd5, 3'd3, 0, -1, 0, 64'd0);

        $display("[TB] randomized fills and bursts");
        for (int i = 16; i < 32; i++) begin
            fillWord(i, {$urandom, $urandom}, 8'hff);
        end
        for (int i = DEPTH - 8; i < DEPTH; i++) begin
            fillWord(i, {$urandom, $urandom}, 8'hff);
        end
        for (int i = 0; i < 12; i++) begin
            fillWord(int'($urandom_range(0, 31)), {$urandom, $urandom},
                     8'($urandom_range(1, 255)));
        end
        for (int i = 0; i < 10; i++) begin
            runBurst("rand", BASE_ADDR + 32'(8 * $urandom_range(0, 16)),
                     2'($urandom_range(0, 2)), 8'($urandom_range(0, 15)),
                     3'd3, 2, -1, 0, 64'd0);
        end
        runBurst("wrap_mod", BASE_ADDR + 32'(8 * (DEPTH - 4)), BURST_INCR, 8'd7,
                 3'd3, 2, -1, 0, 64'd0);

        $display("[TB] address and attribute boundaries");
        fillWord(0, 64'h0123_4567_89ab_cdef, 8'hff);
        runBurst("above_window", BASE_ADDR + 32'(8 * DEPTH), BURST_INCR, 8'd1,
                 3'd3, 0, -1, 0, 64'd0);
        runBurst("below_window", BASE_ADDR - 32'd8, BURST_INCR, 8'd0,
                 3'd3, 0, -1, 0, 64'd0);
        runBurst("bad_size", BASE_ADDR + 32'h10, BURST_INCR, 8'd2,
                 3'd2, 1, -1, 0, 64'd0);
        runBurst("wrap_type", BASE_ADDR + 32'h08, BURST_WRAP, 8'd3,
                 3'd3, 2, -1, 0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
